// File: rtl/uart_tx_frame_if.sv
// Parallel-request / serial-line bundle for the UART frame transmitter.
// The master drives the word and its strobe; the slave returns the line and Busy.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter clocked at the bit rate: start, LSB-first data,
// optional even/odd parity, stop. TX_OUT and Busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_frame_if.slave     bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the flops present them in the
    // same cycle the state is entered, keeping the line purely registered.
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = data_d[cnt_d];
      PARITY:  tx_d   = (^data_d) ^ par_typ_d;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a frame-queue model checked every cycle against an
// 8-bit and a 5-bit instance, plus literal line patterns for directed frames.
module tb_uart_tx_frame;
  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus8 ();
  uart_tx_frame_if #(.DATA_WIDTH(5)) bus5 ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut8 (
    .CLK (clk),
    .RST (rst),
    .bus (bus8.slave)
  );

  uart_tx_frame #(.DATA_WIDTH(5)) dut5 (
    .CLK (clk),
    .RST (rst),
    .bus (bus5.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic par_bit(input logic [8:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Model: each accepted request becomes the list of line levels of its frame;
  // one level is consumed per clock, and an empty list means idle.
  logic exp8[$];
  logic exp5[$];

  always @(posedge clk) begin
    if (!rst) begin
      exp8.delete();
    end else if (exp8.size() != 0) begin
      void'(exp8.pop_front());
    end else if (bus8.Data_Valid) begin
      exp8.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp8.push_back(bus8.P_DATA[i]);
      if (bus8.PAR_EN) exp8.push_back(par_bit({1'b0, bus8.P_DATA}, bus8.PAR_TYP));
      exp8.push_back(1'b1);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      exp5.delete();
    end else if (exp5.size() != 0) begin
      void'(exp5.pop_front());
    end else if (bus5.Data_Valid) begin
      exp5.push_back(1'b0);
      for (int i = 0; i < 5; i++) exp5.push_back(bus5.P_DATA[i]);
      if (bus5.PAR_EN) exp5.push_back(par_bit({4'b0, bus5.P_DATA}, bus5.PAR_TYP));
      exp5.push_back(1'b1);
    end
  end

  logic m_tx8, m_bz8, m_tx5, m_bz5;

  always @(negedge clk) begin
    m_tx8 = (exp8.size() != 0) ? exp8[0] : 1'b1;
    m_bz8 = (exp8.size() != 0);
    m_tx5 = (exp5.size() != 0) ? exp5[0] : 1'b1;
    m_bz5 = (exp5.size() != 0);
    check("model_tx8",   {31'b0, bus8.TX_OUT}, {31'b0, m_tx8});
    check("model_busy8", {31'b0, bus8.Busy},   {31'b0, m_bz8});
    check("model_tx5",   {31'b0, bus5.TX_OUT}, {31'b0, m_tx5});
    check("model_busy5", {31'b0, bus5.Busy},   {31'b0, m_bz5});
  end

  logic tx8_a[0:31];
  logic bz8_a[0:31];
  logic tx5_a[0:31];
  logic bz5_a[0:31];

  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      tx8_a[i] = bus8.TX_OUT;
      bz8_a[i] = bus8.Busy;
      tx5_a[i] = bus5.TX_OUT;
      bz5_a[i] = bus5.Busy;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pack_tx(input int n, input bit w5);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = w5 ? tx5_a[i] : tx8_a[i];
    return v;
  endfunction

  function automatic int busy_cnt(input int n, input bit w5);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += (w5 ? bz5_a[i] : bz8_a[i]) ? 1 : 0;
    return c;
  endfunction

  task automatic strobe8(input logic [7:0] d, input logic pe, input logic pt);
    bus8.P_DATA     = d;
    bus8.PAR_EN     = pe;
    bus8.PAR_TYP    = pt;
    bus8.Data_Valid = 1'b1;
    @(negedge clk);
    bus8.Data_Valid = 1'b0;
    bus8.P_DATA     = ~d;
    bus8.PAR_EN     = ~pe;
    bus8.PAR_TYP    = ~pt;
  endtask

  logic [7:0] d1, d2;

  initial begin
    rst             = 1'b0;
    bus8.P_DATA     = 8'hA5;
    bus8.PAR_EN     = 1'b0;
    bus8.PAR_TYP    = 1'b0;
    bus8.Data_Valid = 1'b1;
    bus5.P_DATA     = 5'h15;
    bus5.PAR_EN     = 1'b0;
    bus5.PAR_TYP    = 1'b0;
    bus5.Data_Valid = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_tx",   {31'b0, bus8.TX_OUT}, 32'd1);
      check("rst_busy", {31'b0, bus8.Busy},   32'd0);
    end
    rst             = 1'b1;
    bus8.Data_Valid = 1'b0;
    bus5.Data_Valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_tx",   {31'b0, bus8.TX_OUT}, 32'd1);
      check("post_rst_busy", {31'b0, bus8.Busy},   32'd0);
    end

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1 then idle 1
    strobe8(8'hA5, 1'b0, 1'b0);
    cap(11);
    check("8n1_line", pack_tx(11, 1'b0), 32'b111_0100_1010);
    check("8n1_busy", busy_cnt(11, 1'b0), 32'd10);

    strobe8(8'hA5, 1'b1, 1'b0);
    cap(12);
    check("a5_even_par", {31'b0, tx8_a[9]}, 32'd0);
    check("a5_even_len", busy_cnt(12, 1'b0), 32'd11);

    strobe8(8'hA5, 1'b1, 1'b1);
    cap(12);
    check("a5_odd_par", {31'b0, tx8_a[9]}, 32'd1);

    strobe8(8'h07, 1'b1, 1'b0);
    cap(12);
    check("07_even_par", {31'b0, tx8_a[9]}, 32'd1);

    strobe8(8'h07, 1'b1, 1'b1);
    cap(12);
    check("07_odd_par", {31'b0, tx8_a[9]}, 32'd0);

    // Held valid with the word changed mid-frame
    bus8.P_DATA     = 8'h3C;
    bus8.PAR_EN     = 1'b0;
    bus8.PAR_TYP    = 1'b0;
    bus8.Data_Valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      tx8_a[i] = bus8.TX_OUT;
      bz8_a[i] = bus8.Busy;
      if (i == 3)  bus8.P_DATA = 8'hFF;
      if (i == 21) bus8.Data_Valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      d1[i] = tx8_a[1 + i];
      d2[i] = tx8_a[12 + i];
    end
    check("held_word1",     {24'b0, d1}, 32'h3C);
    check("held_gap_tx",    {31'b0, tx8_a[10]}, 32'd1);
    check("held_gap_busy",  {31'b0, bz8_a[10]}, 32'd0);
    check("held_start2",    {31'b0, tx8_a[11]}, 32'd0);
    check("held_word2",     {24'b0, d2}, 32'hFF);
    check("held_stop2",     {31'b0, tx8_a[20]}, 32'd1);
    check("held_busy_tot",  busy_cnt(22, 1'b0), 32'd20);

    // Reset during data bit 3 of an 8E1 0x00 frame
    strobe8(8'h00, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_bit3_tx", {31'b0, bus8.TX_OUT}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx",   {31'b0, bus8.TX_OUT}, 32'd1);
    check("mid_rst_busy", {31'b0, bus8.Busy},   32'd0);
    rst = 1'b1;
    strobe8(8'h81, 1'b1, 1'b0);
    cap(12);
    check("after_rst_line", pack_tx(12, 1'b0), 32'b1101_0000_0010);
    check("after_rst_busy", busy_cnt(12, 1'b0), 32'd11);

    // 5-bit instance, 0x15 odd parity: 0,1,0,1,0,1,0,1 then idle 1
    bus5.P_DATA     = 5'h15;
    bus5.PAR_EN     = 1'b1;
    bus5.PAR_TYP    = 1'b1;
    bus5.Data_Valid = 1'b1;
    @(negedge clk);
    bus5.Data_Valid = 1'b0;
    bus5.P_DATA     = 5'h0A;
    cap(9);
    check("w5_line", pack_tx(9, 1'b1), 32'b1_1010_1010);
    check("w5_busy", busy_cnt(9, 1'b1), 32'd8);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
